// File: rtl/pred_ref_sequencer.sv
// Reference buffer and operand sequencer for the angular/planar prediction datapath.
// Optional planar support (LOAD_LEFT state, left buffer) is built when PRED_SEQ_PLANAR_EN is defined.
module pred_ref_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       START,
    input  logic [2:0] PU_IN,
    input  logic       ANGLE_OR_PLANAR_IN,
    input  logic [5:0] ANGLE,
    input  logic       REF_VALID,
    input  logic [7:0] REF_DATA,
    output logic       REF_READY,
    output logic [2:0] PU,
    output logic       angle_or_planar,
    output logic [7:0] REF1,
    output logic [7:0] REF2,
    output logic [7:0] REF1a,
    output logic [7:0] REF2a,
    output logic [7:0] WEIGHT1,
    output logic [7:0] WEIGHT2,
    output logic [4:0] X,
    output logic [4:0] Y,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] o_dbg_state
);
    // Handshakes: a reference sample transfers on a cycle with REF_VALID & REF_READY,
    // an operand sample on a cycle with OUT_VALID & OUT_READY; a presented sample holds until it transfers.

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD_TOP  = 2'd1,
        S_LOAD_LEFT = 2'd2,
        S_GEN       = 2'd3
    } state_t;

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic [2:0]  r_pu;
    logic        r_mode;
    logic [5:0]  r_angle;
    logic [4:0]  r_x;
    logic [4:0]  r_y;
    logic [10:0] r_acc;
    logic        r_ref_ready;
    logic        r_out_valid;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_ref1;
    logic [7:0]  r_ref2;
    logic [7:0]  r_ref1a;
    logic [7:0]  r_ref2a;
    logic [7:0]  r_w1;
    logic [7:0]  r_w2;
    logic [7:0]  r_top [0:64];

    logic [2:0]  w_pu_in;
    logic [5:0]  w_nt;
    logic [4:0]  w_nt_m1;
    logic        w_last_x;
    logic        w_last_y;
    logic        w_last;
    logic        w_last_top;
    logic        w_fire;
    logic        w_top_we;
    logic        w_enter_gen;
    logic [4:0]  w_nx;
    logic [4:0]  w_ny;
    logic [10:0] w_nacc;
    logic [6:0]  w_idx;
    logic [6:0]  w_idx1;
    logic [7:0]  w_ref1;
    logic [7:0]  w_ref2;
    logic [7:0]  w_w1;
    logic [7:0]  w_w2;
    logic [7:0]  w_ref1a;
    logic [7:0]  w_ref2a;

`ifdef PRED_SEQ_PLANAR_EN
    logic [7:0]  r_left [0:32];
    logic        w_left_we;
    logic        w_last_left;
`else
    logic        w_unused_mode;
    assign w_unused_mode = ANGLE_OR_PLANAR_IN;
`endif

    assign w_pu_in    = (PU_IN > 3'd3) ? 3'd3 : PU_IN;
    assign w_nt       = 6'd4 << r_pu;
    assign w_nt_m1    = 5'(w_nt - 6'd1);
    assign w_last_x   = (r_x == w_nt_m1);
    assign w_last_y   = (r_y == w_nt_m1);
    assign w_last     = w_last_x & w_last_y;
    assign w_last_top = (r_cnt == {w_nt, 1'b0});
    assign w_fire     = (r_state == S_GEN) & r_out_valid & OUT_READY;
    assign w_top_we   = (r_state == S_LOAD_TOP) & REF_VALID;

`ifdef PRED_SEQ_PLANAR_EN
    assign w_left_we   = (r_state == S_LOAD_LEFT) & REF_VALID;
    assign w_last_left = (r_cnt == {1'b0, w_nt});
    assign w_enter_gen = (w_top_we & w_last_top & r_mode) | (w_left_we & w_last_left);
    // left[nT] arrives with the very handshake that enters GEN, so take it from the bus.
    assign w_ref1a     = r_mode ? 8'd0 : r_top[{1'b0, w_nt}];
    assign w_ref2a     = r_mode ? 8'd0 : REF_DATA;
`else
    assign w_enter_gen = w_top_we & w_last_top;
    assign w_ref1a     = 8'd0;
    assign w_ref2a     = 8'd0;
`endif

    // Coordinates and accumulator of the sample to present next; in the load states this is (0,0).
    always_comb begin
        w_nx   = 5'd0;
        w_ny   = 5'd0;
        w_nacc = {5'd0, r_angle};
        if (r_state == S_GEN) begin
            if (w_last_x) begin
                w_nx   = 5'd0;
                w_ny   = r_y + 5'd1;
                w_nacc = r_acc + {5'd0, r_angle};
            end else begin
                w_nx   = r_x + 5'd1;
                w_ny   = r_y;
                w_nacc = r_acc;
            end
        end
    end

    assign w_idx  = {2'd0, w_nx} + {1'b0, w_nacc[10:5]};
    assign w_idx1 = w_idx + 7'd1;

    always_comb begin
        w_ref1 = (w_idx <= 7'd64) ? r_top[w_idx] : 8'd0;
        w_ref2 = (w_idx1 <= 7'd64) ? r_top[w_idx1] : 8'd0;
        w_w1   = 8'd32 - {3'd0, w_nacc[4:0]};
        w_w2   = {3'd0, w_nacc[4:0]};
`ifdef PRED_SEQ_PLANAR_EN
        if (!r_mode) begin
            w_ref1 = r_left[{1'b0, w_ny}];
            w_ref2 = r_top[{2'd0, w_nx}];
            w_w1   = {3'd0, w_nt_m1 - w_nx};
            w_w2   = {3'd0, w_nt_m1 - w_ny};
        end
`endif
    end

    // Reference buffers carry no reset; every location read during GEN is written first.
    always_ff @(posedge clk) begin
        if (w_top_we) begin
            r_top[r_cnt] <= REF_DATA;
        end
`ifdef PRED_SEQ_PLANAR_EN
        if (w_left_we) begin
            r_left[r_cnt[5:0]] <= REF_DATA;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 7'd0;
            r_pu        <= 3'd0;
            r_mode      <= 1'b0;
            r_angle     <= 6'd0;
            r_x         <= 5'd0;
            r_y         <= 5'd0;
            r_acc       <= 11'd0;
            r_ref_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ref1      <= 8'd0;
            r_ref2      <= 8'd0;
            r_ref1a     <= 8'd0;
            r_ref2a     <= 8'd0;
            r_w1        <= 8'd0;
            r_w2        <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_pu        <= w_pu_in;
`ifdef PRED_SEQ_PLANAR_EN
                        r_mode      <= ANGLE_OR_PLANAR_IN;
`else
                        r_mode      <= 1'b1;
`endif
                        r_angle     <= ANGLE;
                        r_cnt       <= 7'd0;
                        r_state     <= S_LOAD_TOP;
                        r_ref_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_LOAD_TOP: begin
                    if (REF_VALID) begin
                        r_cnt <= r_cnt + 7'd1;
                        if (w_last_top) begin
                            r_cnt <= 7'd0;
`ifdef PRED_SEQ_PLANAR_EN
                            if (!r_mode) begin
                                r_state <= S_LOAD_LEFT;
                            end
`endif
                        end
                    end
                end
`ifdef PRED_SEQ_PLANAR_EN
                S_LOAD_LEFT: begin
                    if (REF_VALID) begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
`endif
                S_GEN: begin
                    if (w_fire && w_last) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_enter_gen) begin
                r_state     <= S_GEN;
                r_cnt       <= 7'd0;
                r_ref_ready <= 1'b0;
                r_out_valid <= 1'b1;
                r_ref1a     <= w_ref1a;
                r_ref2a     <= w_ref2a;
            end

            if (w_enter_gen || (w_fire && !w_last)) begin
                r_x    <= w_nx;
                r_y    <= w_ny;
                r_acc  <= w_nacc;
                r_ref1 <= w_ref1;
                r_ref2 <= w_ref2;
                r_w1   <= w_w1;
                r_w2   <= w_w2;
            end
        end
    end

    assign REF_READY       = r_ref_ready;
    assign PU              = r_pu;
    assign angle_or_planar = r_mode;
    assign REF1            = r_ref1;
    assign REF2            = r_ref2;
    assign REF1a           = r_ref1a;
    assign REF2a           = r_ref2a;
    assign WEIGHT1         = r_w1;
    assign WEIGHT2         = r_w2;
    assign X               = r_x;
    assign Y               = r_y;
    assign OUT_VALID       = r_out_valid;
    assign BUSY            = r_busy;
    assign DONE            = r_done;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_pred_ref_sequencer.sv
// Randomized scoreboard bench for pred_ref_sequencer; expected samples come from the
// prediction rules evaluated directly over the loaded reference arrays.
module tb_pred_ref_sequencer;
`ifdef PRED_SEQ_PLANAR_EN
    localparam bit PLANAR_EN = 1'b1;
`else
    localparam bit PLANAR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       START;
    logic [2:0] PU_IN;
    logic       ANGLE_OR_PLANAR_IN;
    logic [5:0] ANGLE;
    logic       REF_VALID;
    logic [7:0] REF_DATA;
    logic       REF_READY;
    logic [2:0] PU;
    logic       angle_or_planar;
    logic [7:0] REF1, REF2, REF1a, REF2a, WEIGHT1, WEIGHT2;
    logic [4:0] X, Y;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       BUSY;
    logic       DONE;
    logic [1:0] o_dbg_state;

    pred_ref_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .START              (START),
        .PU_IN              (PU_IN),
        .ANGLE_OR_PLANAR_IN (ANGLE_OR_PLANAR_IN),
        .ANGLE              (ANGLE),
        .REF_VALID          (REF_VALID),
        .REF_DATA           (REF_DATA),
        .REF_READY          (REF_READY),
        .PU                 (PU),
        .angle_or_planar    (angle_or_planar),
        .REF1               (REF1),
        .REF2               (REF2),
        .REF1a              (REF1a),
        .REF2a              (REF2a),
        .WEIGHT1            (WEIGHT1),
        .WEIGHT2            (WEIGHT2),
        .X                  (X),
        .Y                  (Y),
        .OUT_VALID          (OUT_VALID),
        .OUT_READY          (OUT_READY),
        .BUSY               (BUSY),
        .DONE               (DONE),
        .o_dbg_state        (o_dbg_state)
    );

    logic [57:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int done_count = 0;
    int stall_seen = 0;
    bit done_pending = 0;
    bit rand_rdy = 0;
    bit hold_low = 0;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [57:0] pack(input int x, input int y, input int r1, input int r2,
                                         input int r1a, input int r2a, input int w1, input int w2);
        return {5'(x), 5'(y), 8'(r1), 8'(r2), 8'(r1a), 8'(r2a), 8'(w1), 8'(w2)};
    endfunction

    // consumer: OUT_READY changes just after the active edge
    initial begin
        OUT_READY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low) OUT_READY = 1'b0;
            else if (rand_rdy) OUT_READY = ($urandom_range(0, 3) != 0);
            else OUT_READY = 1'b1;
        end
    end

    // monitor / scoreboard
    initial begin
        logic [57:0] got;
        logic [57:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_pending = 0;
            end else begin
                if (done_pending) begin
                    check("done_pulse", 64'(DONE), 64'd1);
                    check("valid_after_last", 64'(OUT_VALID), 64'd0);
                    check("busy_after_last", 64'(BUSY), 64'd0);
                    done_count++;
                    done_pending = 0;
                end else if (DONE) begin
                    check("done_spurious", 64'(DONE), 64'd0);
                end
                if (OUT_VALID) begin
                    got = {X, Y, REF1, REF2, REF1a, REF2a, WEIGHT1, WEIGHT2};
                    if (exp_q.size() == 0) begin
                        check("sample_expected", 64'(exp_q.size() != 0), 64'd1);
                    end else if (OUT_READY) begin
                        exp = exp_q.pop_front();
                        check("sample", 64'(got), 64'(exp));
                        if (exp_q.size() == 0) done_pending = 1;
                    end else begin
                        check("stall_hold", 64'(got), 64'(exp_q[0]));
                        stall_seen++;
                    end
                end
            end
        end
    end

    // driver: one complete PU (start, loads, generation, completion)
    task automatic run_pu(input int pu_in, input bit planar_req, input int ang,
                          input bit pat10, input bit bp, input bit abort);
        int pu_c, nt, idx, acc, iidx, f, guard, d0;
        bit planar, junk_start, bp_done;
        logic [7:0] tp [0:64];
        logic [7:0] lf [0:32];
        logic [7:0] ld [$];
        pu_c   = (pu_in > 3) ? 3 : pu_in;
        nt     = 4 << pu_c;
        planar = PLANAR_EN && planar_req;
        for (int i = 0; i <= 64; i++) tp[i] = pat10 ? 8'(10 * i) : 8'($urandom_range(0, 255));
        for (int i = 0; i <= 32; i++) lf[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i <= 2 * nt; i++) ld.push_back(tp[i]);
        if (planar) for (int i = 0; i <= nt; i++) ld.push_back(lf[i]);
        for (int y = 0; y < nt; y++) begin
            for (int x = 0; x < nt; x++) begin
                if (planar) begin
                    exp_q.push_back(pack(x, y, lf[y], tp[x], tp[nt], lf[nt], nt - 1 - x, nt - 1 - y));
                end else begin
                    acc  = (y + 1) * ang;
                    iidx = acc / 32;
                    f    = acc % 32;
                    exp_q.push_back(pack(x, y, tp[x + iidx], tp[x + iidx + 1], 0, 0, 32 - f, f));
                end
            end
        end

        d0 = done_count;
        START = 1'b1;
        PU_IN = 3'(pu_in);
        ANGLE_OR_PLANAR_IN = !planar_req;
        ANGLE = 6'(ang);
        REF_VALID = 1'b0;
        @(posedge clk);
        #2;
        START = 1'b0;
        check("ref_ready_after_start", 64'(REF_READY), 64'd1);
        check("busy_after_start", 64'(BUSY), 64'd1);
        check("pu_latched", 64'(PU), 64'(pu_c));
        check("mode_latched", 64'(angle_or_planar), 64'(!planar));

        idx = 0;
        guard = 0;
        while (idx < ld.size() && guard < 2000) begin
            REF_VALID = ($urandom_range(0, 3) != 0);
            REF_DATA  = REF_VALID ? ld[idx] : 8'($urandom_range(0, 255));
            @(posedge clk);
            #2;
            if (REF_VALID) idx++;
            guard++;
        end
        // stray strobes during generation must not touch the buffers
        REF_VALID = 1'b1;
        REF_DATA  = 8'hEE;
        check("gen_entry_valid", 64'(OUT_VALID), 64'd1);
        check("gen_entry_ref_ready", 64'(REF_READY), 64'd0);

        guard = 0;
        junk_start = 0;
        bp_done = 0;
        while (done_count == d0 && guard < 5000) begin
            if (abort && OUT_VALID && X == 5'd2 && Y == 5'd1) begin
                rst = 1'b1;
                #1;
                check("rst_operands", 64'({REF1, REF2, REF1a, REF2a, WEIGHT1, WEIGHT2}), 64'd0);
                check("rst_control", 64'({REF_READY, PU, angle_or_planar, X, Y, OUT_VALID, BUSY, DONE, o_dbg_state}), 64'd0);
                exp_q.delete();
                REF_VALID = 1'b0;
                START = 1'b0;
                @(posedge clk);
                #2;
                rst = 1'b0;
                return;
            end
            if (bp && !bp_done && OUT_VALID && X == 5'd1 && Y == 5'd1) begin
                hold_low = 1;
                OUT_READY = 1'b0;
                bp_done = 1;
                repeat (3) @(posedge clk);
                #2;
                hold_low = 0;
                OUT_READY = 1'b1;
            end
            if (!junk_start && OUT_VALID && X == 5'd1 && Y == 5'd0) begin
                START = 1'b1;
                PU_IN = 3'(pu_c ^ 1);
                ANGLE = 6'(ang ^ 5);
                ANGLE_OR_PLANAR_IN = planar_req;
                junk_start = 1;
            end else begin
                START = 1'b0;
            end
            @(posedge clk);
            #2;
            guard++;
        end
        START = 1'b0;
        REF_VALID = 1'b0;
        check("done_seen", 64'(done_count - d0), 64'd1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("pu_held", 64'(PU), 64'(pu_c));
    endtask

    // main sequence
    initial begin
        int s0;
        rst = 1'b1;
        START = 1'b0;
        PU_IN = 3'd0;
        ANGLE_OR_PLANAR_IN = 1'b1;
        ANGLE = 6'd0;
        REF_VALID = 1'b0;
        REF_DATA = 8'd0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_operands", 64'({REF1, REF2, REF1a, REF2a, WEIGHT1, WEIGHT2}), 64'd0);
        check("reset_control", 64'({REF_READY, PU, angle_or_planar, X, Y, OUT_VALID, BUSY, DONE, o_dbg_state}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        rand_rdy = 0;
        run_pu(0, 0, 0, 1, 0, 0);
        run_pu(0, 0, 32, 0, 0, 0);
        run_pu(1, 0, 13, 0, 0, 0);
        run_pu(0, 1, $urandom_range(0, 32), 0, 0, 0);
        s0 = stall_seen;
        run_pu(0, 0, 7, 0, 1, 0);
        check("bp_stall_cycles", 64'(stall_seen - s0), 64'd3);

        rand_rdy = 1;
        for (int i = 0; i < 6; i++) begin
            run_pu($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 32), 0, 0, 0);
        end
        run_pu(6, 0, $urandom_range(0, 32), 0, 0, 0);
        run_pu(1, 0, 20, 0, 0, 1);
        repeat (3) @(posedge clk);
        #2;
        check("idle_after_abort", 64'({BUSY, DONE, OUT_VALID}), 64'd0);
        run_pu(0, 1, 5, 0, 0, 0);

        repeat (5) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pred_ref_sequencer.md
# pred_ref_sequencer

Feeder for the angular/planar prediction datapath. It buffers one PU's reference samples, then produces the per-sample `REF1`/`REF2`/`REF1a`/`REF2a`/`WEIGHT1`/`WEIGHT2` operands in raster order, one sample per cycle, under valid/ready backpressure. Its outputs connect directly to the prediction unit's operand inputs. Like the datapath, it uses no multipliers: all positions and weights come from counters and accumulators.

## Interface
Parameters:
- none; the maximum PU is 32x32 (nT ≤ 32).

Ports (clock and reset first):
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `START`  input  1  request a new PU; sampled only in IDLE.
- `PU_IN`  input  3  size code: 0=4, 1=8, 2=16, 3=32; codes ≥4 are treated as 3. Latched on START.
- `ANGLE_OR_PLANAR_IN`  input  1  1 = angular, 0 = planar. Latched on START.
- `ANGLE`  input  6  intraPredAngle, unsigned 0..32 (vertical, non-negative angles only). Latched on START.
- `REF_VALID`  input  1  reference sample strobe.
- `REF_DATA`  input  8  reference sample value.
- `REF_READY`  output  1  high in the load states.
- `PU`  output  3  latched size code (after clamping).
- `angle_or_planar`  output  1  latched mode bit.
- `REF1`, `REF2`, `REF1a`, `REF2a`  output  8  prediction operands.
- `WEIGHT1`, `WEIGHT2`  output  8  weights; bits [7:6] are always 0.
- `X`, `Y`  output  5  coordinate of the current sample.
- `OUT_VALID`  input/output: `OUT_VALID` is an output (1), `OUT_READY` is an input (1); sample handshake.
- `BUSY`  output  1  high when not in IDLE.
- `DONE`  output  1  one-cycle pulse after the last sample is accepted.

## Operation
- **nT** = 4 << PU.
- **Buffers:** `top[0..64]` and `left[0..32]`, 8-bit register arrays. They are not cleared by reset.
- **States:** IDLE → LOAD_TOP → (LOAD_LEFT if planar) → GEN → IDLE.
- **IDLE:**
  - On START, latch PU/mode/ANGLE.
  - Clear the load counter.
  - Go to LOAD_TOP.
- **LOAD_TOP:**
  - Each `REF_VALID & REF_READY` writes `top[cnt]` and increments `cnt`.
  - After the 2nT+1-th write (index 2nT), go to LOAD_LEFT (planar) or GEN (angular).
- **LOAD_LEFT:**
  - Writes `left[0..nT]` (nT+1 samples), then goes to GEN.
- **GEN:**
  - Raster scan: x = 0..nT-1 inner, y = 0..nT-1 outer.
  - The scan advances only on `OUT_VALID & OUT_READY`.
- **Angular operands:**
  - Accumulator `acc` (11 bits) = (y+1)·ANGLE. It is initialised to ANGLE on entry to GEN and incremented by ANGLE at each row wrap.
  - iIdx = acc>>5; iFact = acc[4:0].
  - `REF1` = top[x+iIdx], `REF2` = top[x+iIdx+1].
  - `WEIGHT1` = 32−iFact, `WEIGHT2` = iFact.
  - `REF1a` = `REF2a` = 0.
- **Planar operands:**
  - `REF1` = left[y], `WEIGHT1` = nT−1−x.
  - `REF2` = top[x], `WEIGHT2` = nT−1−y.
  - `REF1a` = top[nT], `REF2a` = left[nT].
- **End of PU:** after the handshake with x = y = nT−1, go to IDLE and pulse DONE.
- **Mid-operation:** START while BUSY is ignored. `REF_VALID` outside the load states is ignored.

## Timing
- **Reset values:** all outputs 0. State = IDLE.
- **START to load:** START accepted in cycle t puts the block in LOAD_TOP at t+1, with `REF_READY` = 1 from t+1.
- **Load to GEN:** the cycle after the final load handshake, the state is GEN and `OUT_VALID` = 1 with sample (0,0) operands.
- **Operand registers:** operand outputs are registered. After a handshake in cycle t, the next sample is presented at t+1. Throughput is 1 sample/cycle with `OUT_READY` held high.
- **Backpressure:** while `OUT_VALID & !OUT_READY`, all operand, X and Y outputs hold stable.
- **Completion:** a final handshake at t gives `OUT_VALID` = 0 and `DONE` = 1 at t+1, and the block is in IDLE at t+1. A new START is accepted from t+1.
- **Reset mid-operation:** returns to IDLE immediately; outputs 0; DONE is not pulsed.

## Configuration
- **`PRED_SEQ_PLANAR_EN` defined:** planar mode is supported as above, including LOAD_LEFT and the `left` buffer.
- **`PRED_SEQ_PLANAR_EN` undefined:**
  - The `left` buffer and LOAD_LEFT are not built.
  - `ANGLE_OR_PLANAR_IN` is ignored and the latched `angle_or_planar` is forced to 1; every PU is angular.
  - `REF1a`/`REF2a` are tied to 0.

## Test plan
- **Reset:** assert `rst` mid-GEN → same cycle all outputs 0; `BUSY` = 0; next START is accepted normally.
- **Angular, nT=4, ANGLE=0, top[i]=10·i:**
  - 9 loads, then 16 samples with `REF1`=10·x, `REF2`=10·(x+1), `WEIGHT1`=32, `WEIGHT2`=0.
  - `DONE` pulses one cycle after sample (3,3).
- **Angular, nT=4, ANGLE=32:**
  - Row y has `REF1` = top[x+y+1], `WEIGHT2` = 0.
  - Sample (3,3) has `REF1`=top[7], `REF2`=top[8].
- **Angular, nT=8, ANGLE=13:**
  - y=0: `REF1`=top[x], `WEIGHT1`=19, `WEIGHT2`=13.
  - y=2 (acc 39): `REF1`=top[x+1], `WEIGHT1`=25, `WEIGHT2`=7.
- **Planar, nT=4 (with `PRED_SEQ_PLANAR_EN`):**
  - 9 top + 5 left loads.
  - Sample (1,2): `WEIGHT1`=2, `REF1`=left[2], `WEIGHT2`=1, `REF2`=top[1], `REF1a`=top[4], `REF2a`=left[4].
- **Backpressure:** drop `OUT_READY` for 3 cycles at sample (1,1) of nT=4 → outputs frozen at (1,1). Total 16 handshakes; `DONE` appears exactly once.
